// File: rtl/dmem_mmio_responder.sv
// Data-memory slave for the pipelined CPU: word-addressed RAM plus a small MMIO page
// (cycle counter, LEDs, countdown timer with sticky done flag, synchronized switches).
module dmem_mmio_responder #(
    parameter int ADDR_BITS = 12,
    parameter int SW_WIDTH  = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         address_dmem,
    input  logic [31:0]         data,
    input  logic                wren,
    output logic [31:0]         q_dmem,
    input  logic [SW_WIDTH-1:0] switches,
    output logic [SW_WIDTH-1:0] leds,
    output logic                timer_irq
);

    localparam int DEPTH = 1 << ADDR_BITS;

    localparam logic [2:0] OFS_CYCLE  = 3'd0;
    localparam logic [2:0] OFS_LED    = 3'd1;
    localparam logic [2:0] OFS_TIMER  = 3'd2;
    localparam logic [2:0] OFS_STATUS = 3'd3;
    localparam logic [2:0] OFS_SWITCH = 3'd4;

    typedef enum logic [0:0] {
        T_IDLE = 1'b0,
        T_RUN  = 1'b1
    } timer_state_t;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic                 ram_sel;
    logic                 ram_in_range;
    logic                 ram_hit;
    logic                 ram_we;
    logic [ADDR_BITS-1:0] ram_idx;
    logic                 mmio_sel;
    logic                 mmio_we;
    logic [2:0]           mmio_ofs;
    logic                 wr_led;
    logic                 wr_timer;
    logic                 wr_status;

    assign ram_sel      = ~address_dmem[31];
    assign ram_in_range = ~|address_dmem[30:ADDR_BITS];
    assign ram_hit      = ram_sel & ram_in_range;
    assign ram_idx      = address_dmem[ADDR_BITS-1:0];
    assign ram_we       = wren & ram_hit;

    assign mmio_sel  = address_dmem[31];
    assign mmio_ofs  = address_dmem[2:0];
    assign mmio_we   = wren & mmio_sel;
    assign wr_led    = mmio_we && (mmio_ofs == OFS_LED);
    assign wr_timer  = mmio_we && (mmio_ofs == OFS_TIMER);
    assign wr_status = mmio_we && (mmio_ofs == OFS_STATUS);

    // ------------------------------------------------------------------
    // RAM: no reset so it maps onto block RAM; read-first on collision
    // ------------------------------------------------------------------
    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] ram_rd_reg;

    always_ff @(posedge clock) begin
        if (ram_we) begin
            mem[ram_idx] <= data;
        end
        ram_rd_reg <= mem[ram_idx];
    end

    // ------------------------------------------------------------------
    // MMIO registers
    // ------------------------------------------------------------------
    logic [31:0]         cycle_reg;
    logic [SW_WIDTH-1:0] led_reg;
    logic [SW_WIDTH-1:0] sync1_reg;
    logic [SW_WIDTH-1:0] sync2_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_reg <= 32'd0;
            led_reg   <= '0;
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            cycle_reg <= cycle_reg + 32'd1;
            sync1_reg <= switches;
            sync2_reg <= sync1_reg;
            if (wr_led) begin
                led_reg <= data[SW_WIDTH-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Countdown timer
    // ------------------------------------------------------------------
    timer_state_t timer_state_reg;
    timer_state_t timer_state_next;
    logic [31:0]  count_reg;
    logic [31:0]  count_next;
    logic         done_reg;
    logic         done_next;
    logic         running;

    assign running = (timer_state_reg == T_RUN);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer_state_reg <= T_IDLE;
            count_reg       <= 32'd0;
            done_reg        <= 1'b0;
        end else begin
            timer_state_reg <= timer_state_next;
            count_reg       <= count_next;
            done_reg        <= done_next;
        end
    end

    // Priority: a TIMER load overrides expiry entirely; an expiry beats a STATUS clear.
    always_comb begin
        timer_state_next = timer_state_reg;
        count_next       = count_reg;
        done_next        = done_reg;

        if (wr_status && data[0]) begin
            done_next = 1'b0;
        end

        case (timer_state_reg)
            T_RUN: begin
                if (count_reg > 32'd1) begin
                    count_next = count_reg - 32'd1;
                end else begin
                    count_next       = 32'd0;
                    timer_state_next = T_IDLE;
                    done_next        = 1'b1;
                end
            end
            default: begin
                timer_state_next = T_IDLE;
            end
        endcase

        if (wr_timer) begin
            count_next       = data;
            timer_state_next = T_RUN;
            done_next        = done_reg;
        end
    end

    // ------------------------------------------------------------------
    // Read path: MMIO value captured with reset, RAM value from the BRAM register
    // ------------------------------------------------------------------
    logic [31:0] mmio_rd;
    logic [31:0] mmio_q_reg;
    logic        ram_hit_reg;

    always_comb begin
        mmio_rd = 32'd0;
        if (mmio_sel) begin
            case (mmio_ofs)
                OFS_CYCLE:  mmio_rd = cycle_reg;
                OFS_LED:    mmio_rd = {{(32-SW_WIDTH){1'b0}}, led_reg};
                OFS_TIMER:  mmio_rd = count_reg;
                OFS_STATUS: mmio_rd = {30'd0, running, done_reg};
                OFS_SWITCH: mmio_rd = {{(32-SW_WIDTH){1'b0}}, sync2_reg};
                default:    mmio_rd = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mmio_q_reg  <= 32'd0;
            ram_hit_reg <= 1'b0;
        end else begin
            mmio_q_reg  <= mmio_rd;
            ram_hit_reg <= ram_hit;
        end
    end

    // Out-of-range RAM reads fall through to mmio_q_reg, which is zero for non-MMIO addresses.
    assign q_dmem    = ram_hit_reg ? ram_rd_reg : mmio_q_reg;
    assign leds      = led_reg;
    assign timer_irq = done_reg;

endmodule
